seg7_display_mux: RTL and testbench

Downstream consumer of the signed binary-to-BCD converter. Captures its sign/hundreds/tens/ones result on each rising edge of `data_ready`. Time-multiplexes the value onto a 4-digit common-anode seven-segment display as sign, hundreds, tens and ones. Applies leading-zero blanking and shows an error glyph for non-decimal nibbles.

---
 rtl/seg7_display_mux.sv | 87 ++++++++
 tb/tb_seg7_display_mux.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_mux.sv
// seg7_display_mux: captures a signed BCD result and multiplexes it onto a 4-digit common-anode 7-segment display
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   sign, hundreds, tens, ones  BCD result from the converter stage
//   data_ready                rising edge captures the BCD result
//   segments                  {g,f,e,d,c,b,a}, active-low
//   anodes                    active-low digit enables, bit 3 = sign digit, bit 0 = ones
//   display_valid             set once a value has been captured since reset
module seg7_display_mux #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sign,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       data_ready,
    output logic [6:0] segments,
    output logic [3:0] anodes,
    output logic       display_valid
);
    localparam logic [15:0] TC    = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  BLANK = 7'b1111111;
    localparam logic [6:0]  MINUS = 7'b0111111;

    logic        dr_q, s_q, cap, tc;
    logic [3:0]  h_q, t_q, o_q;
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [6:0]  digit;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b0000110;
        endcase
    endfunction

    assign cap = data_ready & ~dr_q;
    assign tc  = cnt == TC;

    // Blanking compares only against zero, so a non-decimal nibble still shows E.
    always_comb begin
        digit = idx == 2'd3 ? (s_q ? MINUS : BLANK) :
                idx == 2'd2 ? (h_q == 4'd0 ? BLANK : glyph(h_q)) :
                idx == 2'd1 ? (h_q == 4'd0 && t_q == 4'd0 ? BLANK : glyph(t_q)) :
                glyph(o_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_q          <= 1'b0;
            cnt           <= '0;
            idx           <= '0;
            s_q           <= 1'b0;
            h_q           <= '0;
            t_q           <= '0;
            o_q           <= '0;
            display_valid <= 1'b0;
            segments      <= BLANK;
            anodes        <= 4'hf;
        end else begin
            dr_q     <= data_ready;
            cnt      <= tc ? '0 : cnt + 16'd1;
            segments <= display_valid ? digit : BLANK;
            anodes   <= display_valid ? ~(4'b0001 << idx) : 4'hf;
            if (tc) idx <= idx + 2'd1;
            if (cap) begin
                s_q           <= sign;
                h_q           <= hundreds;
                t_q           <= tens;
                o_q           <= ones;
                display_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_display_mux.sv
// tb_seg7_display_mux: directed self-checking bench for seg7_display_mux at REFRESH_DIV 4 and 1
module tb_seg7_display_mux;
    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000;
    localparam logic [6:0] GM = 7'b0111111, GB = 7'b1111111, GE = 7'b0000110;

    logic       clk = 1'b0, rst, sign, data_ready;
    logic [3:0] hundreds, tens, ones;
    logic [6:0] seg4, seg1;
    logic [3:0] an4, an1;
    logic       v4, v1;
    int         passed = 0, total = 0;
    logic [6:0] o3, o2, o1, o0;
    logic       rok;

    seg7_display_mux #(.REFRESH_DIV(4)) u4 (
        .clk(clk), .rst(rst), .sign(sign), .hundreds(hundreds), .tens(tens), .ones(ones),
        .data_ready(data_ready), .segments(seg4), .anodes(an4), .display_valid(v4)
    );
    seg7_display_mux #(.REFRESH_DIV(1)) u1 (
        .clk(clk), .rst(rst), .sign(sign), .hundreds(hundreds), .tens(tens), .ones(ones),
        .data_ready(data_ready), .segments(seg1), .anodes(an1), .display_valid(v1)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pick(input logic [3:0] a, input logic [6:0] e3, e2, e1, e0);
        case (a)
            4'b1110: pick = e0;
            4'b1101: pick = e1;
            4'b1011: pick = e2;
            4'b0111: pick = e3;
            default: pick = 7'bzzzzzzz;
        endcase
    endfunction

    // One full scan of the DIV=4 instance: glyph seen on each digit, and whether
    // every anode pattern was one-hot-low and every change a single step left.
    task automatic collect();
        logic [3:0] prev;
        o3 = 7'bz; o2 = 7'bz; o1 = 7'bz; o0 = 7'bz; rok = 1'b1; prev = 4'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (an4)
                4'b1110: o0 = seg4;
                4'b1101: o1 = seg4;
                4'b1011: o2 = seg4;
                4'b0111: o3 = seg4;
                default: rok = 1'b0;
            endcase
            if (i > 0 && an4 !== prev && an4 !== {prev[2:0], prev[3]}) rok = 1'b0;
            prev = an4;
        end
    endtask

    task automatic capture(input logic s, input logic [3:0] h, t, o);
        @(negedge clk);
        sign = s; hundreds = h; tens = t; ones = o; data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++; if (seg4 !== GB) $display("FAIL reset_seg got %b want %b", seg4, GB); else passed++;
        total++; if (an4 !== 4'hf) $display("FAIL reset_an got %b want 1111", an4); else passed++;
        total++; if (v4 !== 1'b0) $display("FAIL reset_valid got %b want 0", v4); else passed++;
        total++; if ({v1, an1, seg1} !== {1'b0, 4'hf, GB}) $display("FAIL reset_fast got %b want 0_1111_1111111", {v1, an1, seg1}); else passed++;
    endtask

    task automatic test_plus127();
        capture(1'b0, 4'd1, 4'd2, 4'd7);
        total++; if (v4 !== 1'b1) $display("FAIL p127_valid got %b want 1", v4); else passed++;
        collect();
        total++; if (o3 !== GB) $display("FAIL p127_d3 got %b want %b", o3, GB); else passed++;
        total++; if (o2 !== G1) $display("FAIL p127_d2 got %b want %b", o2, G1); else passed++;
        total++; if (o1 !== G2) $display("FAIL p127_d1 got %b want %b", o1, G2); else passed++;
        total++; if (o0 !== G7) $display("FAIL p127_d0 got %b want %b", o0, G7); else passed++;
        total++; if (rok !== 1'b1) $display("FAIL p127_anode_seq got %b want 1", rok); else passed++;
    endtask

    task automatic test_negative();
        capture(1'b1, 4'd1, 4'd2, 4'd8);
        collect();
        total++; if ({o3, o2, o1, o0} !== {GM, G1, G2, G8}) $display("FAIL m128 got %b want %b", {o3, o2, o1, o0}, {GM, G1, G2, G8}); else passed++;
        capture(1'b1, 4'd0, 4'd0, 4'd5);
        collect();
        total++; if (o3 !== GM) $display("FAIL m5_d3 got %b want %b", o3, GM); else passed++;
        total++; if (o2 !== GB) $display("FAIL m5_d2 got %b want %b", o2, GB); else passed++;
        total++; if (o1 !== GB) $display("FAIL m5_d1 got %b want %b", o1, GB); else passed++;
        total++; if (o0 !== G5) $display("FAIL m5_d0 got %b want %b", o0, G5); else passed++;
    endtask

    task automatic test_zero_error();
        capture(1'b0, 4'd0, 4'd0, 4'd0);
        collect();
        total++; if ({o3, o2, o1, o0} !== {GB, GB, GB, G0}) $display("FAIL zero got %b want %b", {o3, o2, o1, o0}, {GB, GB, GB, G0}); else passed++;
        capture(1'b0, 4'd12, 4'd0, 4'd3);
        collect();
        total++; if (o2 !== GE) $display("FAIL err_d2 got %b want %b", o2, GE); else passed++;
        total++; if (o1 !== G0) $display("FAIL err_d1 got %b want %b", o1, G0); else passed++;
        total++; if (o0 !== G3) $display("FAIL err_d0 got %b want %b", o0, G3); else passed++;
        total++; if (o3 !== GB) $display("FAIL err_d3 got %b want %b", o3, GB); else passed++;
    endtask

    task automatic test_level_hold();
        @(negedge clk);
        sign = 1'b0; hundreds = 4'd0; tens = 4'd4; ones = 4'd2; data_ready = 1'b1;
        repeat (2) @(negedge clk);
        collect();
        total++; if ({o3, o2, o1, o0} !== {GB, GB, G4, G2}) $display("FAIL hold_42 got %b want %b", {o3, o2, o1, o0}, {GB, GB, G4, G2}); else passed++;
        tens = 4'd9; ones = 4'd9;
        repeat (2) @(negedge clk);
        collect();
        total++; if ({o3, o2, o1, o0} !== {GB, GB, G4, G2}) $display("FAIL hold_still_42 got %b want %b", {o3, o2, o1, o0}, {GB, GB, G4, G2}); else passed++;
        data_ready = 1'b0;
        @(negedge clk);
        data_ready = 1'b1;
        repeat (2) @(negedge clk);
        collect();
        total++; if ({o3, o2, o1, o0} !== {GB, GB, G9, G9}) $display("FAIL hold_99 got %b want %b", {o3, o2, o1, o0}, {GB, GB, G9, G9}); else passed++;
        data_ready = 1'b0;
    endtask

    // DIV=1 advances the index on every edge, so the capture edge is always a terminal-count edge.
    task automatic test_fast_refresh();
        logic [3:0] prev;
        @(negedge clk);
        sign = 1'b1; hundreds = 4'd1; tens = 4'd2; ones = 4'd8; data_ready = 1'b1;
        @(negedge clk);
        prev = an1;
        total++; if (seg1 !== pick(an1, GB, GB, G9, G9)) $display("FAIL fast_old got %b want %b", seg1, pick(an1, GB, GB, G9, G9)); else passed++;
        data_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++; if (an1 !== {prev[2:0], prev[3]}) $display("FAIL fast_an%0d got %b want %b", i, an1, {prev[2:0], prev[3]}); else passed++;
            total++; if (seg1 !== pick(an1, GM, G1, G2, G8)) $display("FAIL fast_seg%0d got %b want %b", i, seg1, pick(an1, GM, G1, G2, G8)); else passed++;
            prev = an1;
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (seg4 !== GB) $display("FAIL arst_seg got %b want %b", seg4, GB); else passed++;
        total++; if (an4 !== 4'hf) $display("FAIL arst_an got %b want 1111", an4); else passed++;
        total++; if (v4 !== 1'b0) $display("FAIL arst_valid got %b want 0", v4); else passed++;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (seg4 !== GB || an4 !== 4'hf || v4 !== 1'b0) bad++;
        end
        total++; if (bad != 0) $display("FAIL post_reset_blank got %0d nonblank cycles want 0", bad); else passed++;
    endtask

    task automatic test_reset_release_high();
        @(negedge clk);
        rst = 1'b1; sign = 1'b0; hundreds = 4'd0; tens = 4'd0; ones = 4'd7; data_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (v4 !== 1'b0) $display("FAIL rel_valid_before got %b want 0", v4); else passed++;
        @(negedge clk);
        total++; if (v4 !== 1'b1) $display("FAIL rel_valid_after got %b want 1", v4); else passed++;
        data_ready = 1'b0;
        collect();
        total++; if ({o3, o2, o1, o0} !== {GB, GB, GB, G7}) $display("FAIL rel_value got %b want %b", {o3, o2, o1, o0}, {GB, GB, GB, G7}); else passed++;
    endtask

    initial begin
        rst = 1'b1; data_ready = 1'b0; sign = 1'b0; hundreds = '0; tens = '0; ones = '0;
        #2;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_plus127();
        test_negative();
        test_zero_error();
        test_level_hold();
        test_fast_refresh();
        test_reset_mid();
        test_reset_release_high();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
